switch_conditioner: RTL

Front-end conditioning stage for the washer's panel switches (power, start/pause, model select, clothes add, order time, clean time). It synchronises each raw board input to `clk`, debounces it against a shared millisecond tick, and produces a clean level plus single-cycle rise, fall and long-hold pulses and a toggle state. Its outputs feed the washer's control blocks (system state, water amount, model change, order, light control) in place of per-input debounce instances.

---
 rtl/switch_conditioner_pkg.sv | 23 ++
 rtl/switch_channel.sv | 95 +++++++++
 rtl/switch_conditioner.sv | 55 +++++
 3 files changed

// File: rtl/switch_conditioner_pkg.sv
// Shared washer panel definitions: switch channel indices and tick divider helpers.
package switch_conditioner_pkg;

    localparam int CH_POWER = 0;
    localparam int CH_START = 1;
    localparam int CH_MODEL = 2;
    localparam int CH_ADD   = 3;
    localparam int CH_ORDER = 4;
    localparam int CH_CLEAN = 5;

    localparam int CLK_HZ_DEFAULT = 100_000_000;
    localparam int TICK_DIV       = CLK_HZ_DEFAULT / 1000;

    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_channel.sv
// One panel switch: two-flop sync, tick-based debounce, edge/toggle pulses and long-hold detect.
module switch_channel
    import switch_conditioner_pkg::*;
#(
    parameter int DB_MS   = 20,
    parameter int HOLD_MS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic hold_o,
    output logic toggle_o
);

    localparam int DW = cnt_w(DB_MS);
    localparam int HW = $clog2(HOLD_MS + 1);

    logic [1:0]    sync_q;
    logic          sync;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          hold_q, hold_d;
    logic          tog_q, tog_d;

    assign sync = sync_q[1];

    always_comb begin
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        level_d    = level_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        hold_d     = 1'b0;
        tog_d      = tog_q;

        // Any cycle of agreement wipes the disagreement run, so glitches leave no trace.
        if (sync == level_q) begin
            db_cnt_d = '0;
        end else if (tick_i) begin
            if (db_cnt_q == DW'(DB_MS - 1)) begin
                level_d  = sync;
                db_cnt_d = '0;
                rise_d   = sync;
                fall_d   = ~sync;
            end else begin
                db_cnt_d = db_cnt_q + DW'(1);
            end
        end

        if (rise_d) tog_d = ~tog_q;

        if (!level_q) begin
            hold_cnt_d = '0;
        end else if (tick_i && (hold_cnt_q != HW'(HOLD_MS))) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
            hold_d     = (hold_cnt_d == HW'(HOLD_MS));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            level_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            hold_q     <= 1'b0;
            tog_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], sw_i};
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            hold_q     <= hold_d;
            tog_q      <= tog_d;
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign hold_o   = hold_q;
    assign toggle_o = tog_q;

endmodule

// File: rtl/switch_conditioner.sv
// Washer panel switch front end: shared 1 kHz prescaler feeding one conditioner per switch.
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int N_CH    = 6,
    parameter int CLK_HZ  = 100_000_000,
    parameter int DB_MS   = 20,
    parameter int HOLD_MS = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] sw_level,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall,
    output logic [N_CH-1:0] sw_hold,
    output logic [N_CH-1:0] sw_toggle,
    output logic            ms_tick
);

    localparam int DIV = tick_div(CLK_HZ);
    localparam int PW  = cnt_w(DIV);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q + PW'(1);
        if (pre_q == PW'(DIV - 1)) pre_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) pre_q <= '0;
        else        pre_q <= pre_d;
    end

    assign ms_tick = (pre_q == PW'(DIV - 1));

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        switch_channel #(
            .DB_MS  (DB_MS),
            .HOLD_MS(HOLD_MS)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick_i  (ms_tick),
            .sw_i    (sw_in[g]),
            .level_o (sw_level[g]),
            .rise_o  (sw_rise[g]),
            .fall_o  (sw_fall[g]),
            .hold_o  (sw_hold[g]),
            .toggle_o(sw_toggle[g])
        );
    end

endmodule
